shift_counter_gen: RTL

- Parametrised multi-mode shift/sequence counter driving the board LED bank from slide switches.
- Successor to the fixed 5-bit ring/Johnson counter, generalised in width.
- Adds direction, enable, a step prescaler, binary and LFSR modes, and a wrap indication.
- Sits between the switch/clock inputs and the LED outputs in the lab top level.

---
 rtl/shift_counter_pkg.sv | 49 ++++
 rtl/step_prescaler.sv | 30 +++
 rtl/shift_counter_gen.sv | 62 ++++++
 3 files changed

// File: rtl/shift_counter_pkg.sv
// Shared mode encoding and the next-state function used by the counter
// and by anything that needs to predict the counter's sequence.
package shift_counter_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    MODE_RING    = 2'd0,
    MODE_JOHNSON = 2'd1,
    MODE_BINARY  = 2'd2,
    MODE_LFSR    = 2'd3
  } mode_e;

  // Works on a MAX_W-wide container; only the low 'width' bits are meaningful.
  function automatic logic [MAX_W-1:0] next_state(
    input logic [MAX_W-1:0] s,
    input mode_e            mode,
    input logic             dir,
    input logic [MAX_W-1:0] taps,
    input int unsigned      width
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] top_bit;
    logic [MAX_W-1:0] res;
    logic             msb;
    logic             lsb;
    mask = '1;
    if (width < MAX_W) mask = (MAX_W'(1) << width) - MAX_W'(1);
    top_bit = MAX_W'(1) << (width - 1);
    msb     = |(s & top_bit);
    lsb     = s[0];
    res     = '0;
    case (mode)
      MODE_RING:
        res = dir ? ((s >> 1) | (lsb ? top_bit : '0))
                  : ((s << 1) | MAX_W'(msb));
      MODE_JOHNSON:
        res = dir ? ((s >> 1) | (lsb ? '0 : top_bit))
                  : ((s << 1) | MAX_W'(!msb));
      MODE_BINARY:
        res = dir ? (s - MAX_W'(1)) : (s + MAX_W'(1));
      default:
        // An all-zero LFSR would lock up, so it is kicked back to 1.
        res = (s == '0) ? MAX_W'(1) : ((s << 1) | MAX_W'(^(s & taps)));
    endcase
    return res & mask;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides enabled clocks by DIV; tick marks the cycle an advance is due.
module step_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && !clear && (count == LAST);

  // The count is frozen while disabled so counting resumes where it stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/shift_counter_gen.sv
// Multi-mode ring/Johnson/binary/LFSR counter for the LED bank, with load,
// prescaled stepping and a wrap pulse when the sequence returns to the seed.
module shift_counter_gen
  import shift_counter_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter int               DIV   = 1,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(5'b10100)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_en,
  input  logic [1:0]       sw_mode,
  input  logic             sw_dir,
  input  logic             sw_control,
  input  logic [WIDTH-1:0] sw_nums,
  output logic [WIDTH-1:0] leds,
  output logic             step,
  output logic             wrap
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] next_val;
  logic             tick;

  step_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sw_en),
    .clear (sw_control),
    .tick  (tick)
  );

  assign next_val = WIDTH'(next_state(MAX_W'(state), mode_e'(sw_mode), sw_dir,
                                      MAX_W'(TAPS), WIDTH));

  // Load wins over an advance due on the same edge; the prescaler is cleared too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WIDTH'(1);
      seed  <= WIDTH'(1);
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else if (sw_control) begin
      state <= sw_nums;
      seed  <= sw_nums;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else if (tick) begin
      state <= next_val;
      step  <= 1'b1;
      wrap  <= (next_val == seed);
    end else begin
      step  <= 1'b0;
      wrap  <= 1'b0;
    end
  end

  assign leds = state;

endmodule
